// File: rtl/fas_seq_pkg.sv
// Shared definitions for the multi-precision add/subtract sequencer:
// state encoding, slice width and operation codes.
package fas_seq_pkg;

  localparam int BYTE_W = 8;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/FAS_8bit.sv
// 8-bit add/sub slice. The B operand is conditioned by XOR with the carry-in
// internally, so callers pre-XOR B with the carry to obtain a plain add.
module FAS_8bit (
  input  logic [7:0] i_A,
  input  logic [7:0] i_B,
  input  logic       i_C,
  output logic [7:0] o_S,
  output logic       o_C
);

  logic [7:0] b_cond_s;

  assign b_cond_s   = i_B ^ {8{i_C}};
  assign {o_C, o_S} = {1'b0, i_A} + {1'b0, b_cond_s} + {8'd0, i_C};

endmodule

// File: rtl/fas_mp_seq.sv
// Multi-precision add/subtract sequencer: one FAS_8bit slice walked LSB-first
// over NBYTES bytes. Define FAS_SEQ_FLAGS_EN to build the o_ovf/o_zero flags.
module fas_mp_seq
  import fas_seq_pkg::*;
#(
  parameter int NBYTES = 4
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_valid,
  output logic                     o_ready,
  input  logic                     i_sub,
  input  logic [BYTE_W*NBYTES-1:0] i_A,
  input  logic [BYTE_W*NBYTES-1:0] i_B,
  output logic                     o_valid,
  input  logic                     i_ready,
  output logic [BYTE_W*NBYTES-1:0] o_S,
  output logic                     o_C,
  output logic                     o_ovf,
  output logic                     o_zero,
  output logic                     o_busy
);

  localparam int W  = BYTE_W * NBYTES;
  localparam int IW = $clog2(NBYTES);
  localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

  state_e              state_q;
  logic [W-1:0]        a_q;
  logic [W-1:0]        b_q;
  logic                sub_q;
  logic [IW-1:0]       idx_q;
  logic                carry_q;
  logic [W-1:0]        s_q;
  logic                c_q;

  logic [BYTE_W-1:0]   a_byte_s;
  logic [BYTE_W-1:0]   b_byte_s;
  logic [BYTE_W-1:0]   b_eff_s;
  logic [BYTE_W-1:0]   slice_b_s;
  logic [BYTE_W-1:0]   sum_s;
  logic                cout_s;

  assign a_byte_s  = a_q[idx_q*BYTE_W +: BYTE_W];
  assign b_byte_s  = b_q[idx_q*BYTE_W +: BYTE_W];
  assign b_eff_s   = (sub_q == OP_SUB) ? ~b_byte_s : b_byte_s;
  // Pre-XOR with the carry so the slice's internal XOR cancels it out.
  assign slice_b_s = b_eff_s ^ {BYTE_W{carry_q}};

  FAS_8bit u_slice (
    .i_A (a_byte_s),
    .i_B (slice_b_s),
    .i_C (carry_q),
    .o_S (sum_s),
    .o_C (cout_s)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= OP_ADD;
      idx_q   <= '0;
      carry_q <= 1'b0;
      s_q     <= '0;
      c_q     <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (i_valid) begin
            a_q     <= i_A;
            b_q     <= i_B;
            sub_q   <= i_sub;
            idx_q   <= '0;
            carry_q <= i_sub;
            state_q <= ST_RUN;
          end
        end
        ST_RUN: begin
          s_q[idx_q*BYTE_W +: BYTE_W] <= sum_s;
          carry_q                     <= cout_s;
          if (idx_q == LAST_IDX) begin
            c_q     <= cout_s;
            state_q <= ST_DONE;
          end else begin
            idx_q <= idx_q + IW'(1);
          end
        end
        ST_DONE: begin
          if (i_ready) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_ready = (state_q == ST_IDLE);
  assign o_valid = (state_q == ST_DONE);
  assign o_busy  = (state_q != ST_IDLE);
  assign o_S     = s_q;
  assign o_C     = c_q;

`ifdef FAS_SEQ_FLAGS_EN
  logic ovf_q;
  logic zero_q;
  logic nz_acc_q;

  // Zero flag is a running OR of result bytes; both flags latch on the last byte.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
      nz_acc_q <= 1'b0;
    end else if (state_q == ST_IDLE && i_valid) begin
      nz_acc_q <= 1'b0;
    end else if (state_q == ST_RUN) begin
      nz_acc_q <= nz_acc_q | (|sum_s);
      if (idx_q == LAST_IDX) begin
        ovf_q  <= (a_byte_s[BYTE_W-1] == b_eff_s[BYTE_W-1]) &
                  (sum_s[BYTE_W-1] != a_byte_s[BYTE_W-1]);
        zero_q <= ~(nz_acc_q | (|sum_s));
      end
    end
  end

  assign o_ovf  = ovf_q;
  assign o_zero = zero_q;
`else
  assign o_ovf  = 1'b0;
  assign o_zero = 1'b0;
`endif

endmodule

// File: doc/fas_mp_seq.md
Name: fas_mp_seq

Overview:
- Multi-precision add/subtract sequencer. Time-multiplexes one 8-bit add/sub slice (the existing FAS_8bit) over an NBYTES-wide operand pair, least-significant byte first, one byte per clock.
- Sits between an ALU command source (valid/ready) and the result consumer (valid/ready).
- Gives the ALU wide ADD/SUB without replicating adders.

Parameters:
- NBYTES, 4, number of byte slices per operation (W = 8*NBYTES); legal range 2..16.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, synchronous, active-high.
- i_valid  in  1  command valid.
- o_ready  out  1  command accepted when i_valid & o_ready.
- i_sub  in  1  0 = A+B, 1 = A-B.
- i_A  in  W  operand A, unsigned or two's complement.
- i_B  in  W  operand B.
- o_valid  out  1  result valid.
- i_ready  in  1  consumer accepts result when o_valid & i_ready.
- o_S  out  W  result.
- o_C  out  1  final carry; for SUB, 1 = no borrow (A >= B unsigned).
- o_ovf  out  1  signed overflow (optional feature).
- o_zero  out  1  result == 0 (optional feature).
- o_busy  out  1  high in RUN and DONE.

Behaviour:
- Clock and reset: single clock i_clk. Reset i_rst is synchronous, active-high.
- Reset values: state = IDLE; o_ready = 1 (combinational from IDLE); o_valid, o_busy, o_C, o_ovf, o_zero = 0; o_S = 0; byte index = 0; carry register = 0.
- Reset mid-operation: the operation is abandoned with no result emitted, and the block is in IDLE the cycle after reset deasserts.
- FSM states: IDLE, RUN, DONE (encoding from the package).
- IDLE:
  - o_ready = 1.
  - On i_valid: capture i_A, i_B and i_sub into operand registers; idx <= 0; carry <= i_sub; go to RUN.
  - i_valid while not in IDLE is ignored; it is not queued.
- RUN: one byte per cycle.
  - Effective B byte: Beff = i_sub ? ~B[idx] : B[idx].
  - Slice drive: i_A = A[idx], i_C = carry, i_B = Beff ^ carry. The slice XORs i_B with i_C internally, so the slice's effective addend is Beff with carry-in = carry.
  - Registered each cycle: S[idx] <= slice sum; carry <= slice carry out; idx <= idx + 1.
  - When idx == NBYTES-1: latch o_C from the slice carry out; go to DONE.
- DONE:
  - o_valid = 1.
  - o_S, o_C and flags are stable and unchanged until handshake.
  - On i_ready: go to IDLE, o_valid drops next cycle.
  - o_S retains its last value in IDLE.
- Latency and throughput:
  - o_valid rises exactly NBYTES cycles after the accept edge.
  - Minimum spacing between accepts is NBYTES+2 cycles.
- Width rules:
  - Results are modulo 2^W.
  - idx width is clog2(NBYTES); idx never wraps past NBYTES-1.
- Backpressure: i_ready low in DONE holds all outputs indefinitely; o_ready stays 0.

Optional Feature:
- Macro: FAS_SEQ_FLAGS_EN.
- Defined:
  - o_ovf latched on the last byte as (A[W-1] == Beff[7]) & (S[W-1] != A[W-1]).
  - o_zero = NOR of all result bytes, accumulated as a running OR across RUN.
  - Both flags are valid with o_valid.
- Undefined: o_ovf and o_zero are tied to 0, and the flag logic is absent.

Decomposition:
- Package fas_seq_pkg:
  - state encoding localparams ST_IDLE = 2'd0, ST_RUN = 2'd1, ST_DONE = 2'd2;
  - BYTE_W = 8;
  - OP_ADD = 1'b0, OP_SUB = 1'b1.
- Sub-module: one instance of the existing FAS_8bit as the byte slice. No other sub-modules; the FSM, operand mux and conditioning XOR stay in fas_mp_seq.

Test Plan:
- Carry ripple: NBYTES=4, ADD 0x000000FF + 0x00000001 → o_S=0x00000100, o_C=0, o_valid exactly 4 cycles after accept.
- Borrow: SUB 0x00000000 - 0x00000001 → o_S=0xFFFFFFFF, o_C=0, o_ovf=0, o_zero=0; SUB 0x12345678 - 0x12345678 → o_S=0, o_C=1, o_zero=1.
- Signed overflow: ADD 0x7FFFFFFF + 0x00000001 → o_S=0x80000000, o_ovf=1, o_C=0; SUB 0x80000000 - 0x00000001 → o_S=0x7FFFFFFF, o_ovf=1, o_C=1.
- Backpressure: hold i_ready=0 for 5 cycles in DONE while pulsing i_valid with new operands → o_S and o_valid stable, o_ready=0, the new command is not accepted; after i_ready=1, o_valid falls next cycle and o_ready=1.
- Reset mid-op: assert i_rst for 1 cycle while idx=2 → next cycle o_valid=0, o_S=0, o_ready=1, state IDLE; the following command completes correctly.
- Random: 1000 random ADD/SUB commands with random i_ready stalls vs a reference model for NBYTES=2 and NBYTES=4, with and without FAS_SEQ_FLAGS_EN.
